// File: rtl/glitch_sequencer.sv
// -----------------------------------------------------------------------------
// glitch_sequencer
//
// Drives the glitch pin from parameters that uart_handler has programmed:
// delay, pulse width, pulse count and inter-pulse spacing.
//
// Operation:
//   arm      A one-cycle arm strobe snapshots the parameters into shadow
//            registers. The sequencer then waits for a trigger.
//   fire     After a rising edge on the asynchronous trigger pin, the
//            sequencer waits the programmed delay. It then emits the pulse
//            train.
//   control  abort_i cancels the sequence at any point.
//
// Optional feature:
//   GLITCH_TRIG_TIMEOUT_EN   When this macro is defined, the sequencer gives
//                            up waiting for a trigger after TIMEOUT_CYCLES
//                            armed cycles. It then pulses timeout_o.
//
// Parameters:
//   TRIG_SYNC_STAGES  trigger synchronizer depth (>= 2)
//   TIMEOUT_CYCLES    armed timeout in clk cycles (macro build only)
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   delay_i [15:0]   cycles from trigger edge to first pulse
//   width_i [7:0]    pulse high time, cycles
//   num_pulses_i[7:0] pulses per trigger
//   pulse_spacing_i[15:0] low time between pulses, cycles (0 acts as 1)
//   arm_i            one-cycle arm strobe; only accepted in IDLE
//   abort_i          level; returns to IDLE on the next cycle
//   trigger_i        external trigger, asynchronous to clk
//   glitch_o         glitch pulse output (state == PULSE)
//   busy_o           state != IDLE
//   armed_o          state == ARMED
//   done_o           one-cycle strobe, sequence completed
//   timeout_o        one-cycle strobe, armed wait timed out
//   state_dbg [2:0]  current FSM state encoding, for debug/checkers
//
// Handshake: arm_i is a strobe with implicit ready = (state == IDLE). A strobe
// that arrives outside IDLE is dropped, and the shadow registers keep their
// values.
// -----------------------------------------------------------------------------
module glitch_sequencer #(
    parameter int TRIG_SYNC_STAGES = 2,
    parameter int TIMEOUT_CYCLES   = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] delay_i,
    input  logic [7:0]  width_i,
    input  logic [7:0]  num_pulses_i,
    input  logic [15:0] pulse_spacing_i,
    input  logic        arm_i,
    input  logic        abort_i,
    input  logic        trigger_i,
    output logic        glitch_o,
    output logic        busy_o,
    output logic        armed_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_SPACE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state;

    // Shadow copies of the programmed parameters, taken at arm.
    logic [15:0] delay_q;
    logic [7:0]  width_q;
    logic [7:0]  num_q;
    logic [15:0] spacing_q;

    // cnt is shared by the DELAY and SPACE phases. They never overlap.
    logic [15:0] cnt;
    logic [7:0]  wcnt;
    logic [7:0]  pulses_left;

    // The synchronizer chain and the edge register reset high. This way a
    // trigger pin that is already high when reset releases does not read as
    // a rising edge.
    logic [TRIG_SYNC_STAGES-1:0] trig_sync;
    logic                        trig_prev;
    logic                        trig_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_sync <= '1;
            trig_prev <= 1'b1;
        end else begin
            trig_sync <= {trig_sync[TRIG_SYNC_STAGES-2:0], trigger_i};
            trig_prev <= trig_sync[TRIG_SYNC_STAGES-1];
        end
    end

    assign trig_rise = trig_sync[TRIG_SYNC_STAGES-1] & ~trig_prev;

`ifdef GLITCH_TRIG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            delay_q     <= '0;
            width_q     <= '0;
            num_q       <= '0;
            spacing_q   <= '0;
            cnt         <= '0;
            wcnt        <= '0;
            pulses_left <= '0;
`ifdef GLITCH_TRIG_TIMEOUT_EN
            tcnt        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else if (abort_i) begin
            // Abort also outranks an arm strobe that arrives in the same cycle.
            state <= S_IDLE;
`ifdef GLITCH_TRIG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef GLITCH_TRIG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arm_i) begin
                        delay_q   <= delay_i;
                        width_q   <= width_i;
                        num_q     <= num_pulses_i;
                        spacing_q <= pulse_spacing_i;
`ifdef GLITCH_TRIG_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                        // A request with no pulses completes at once and
                        // never arms.
                        if (width_i == 8'd0 || num_pulses_i == 8'd0)
                            state <= S_DONE;
                        else
                            state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    // A trigger edge wins over a timeout that expires in
                    // the same cycle.
                    if (trig_rise) begin
                        pulses_left <= num_q;
                        wcnt        <= width_q - 8'd1;
                        if (delay_q == 16'd0) begin
                            state <= S_PULSE;
                        end else begin
                            cnt   <= delay_q - 16'd1;
                            state <= S_DELAY;
                        end
                    end
`ifdef GLITCH_TRIG_TIMEOUT_EN
                    else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state     <= S_IDLE;
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                S_DELAY: begin
                    if (cnt == 16'd0) state <= S_PULSE;
                    else              cnt   <= cnt - 16'd1;
                end
                S_PULSE: begin
                    if (wcnt == 8'd0) begin
                        pulses_left <= pulses_left - 8'd1;
                        if (pulses_left == 8'd1) begin
                            state <= S_DONE;
                        end else begin
                            // A spacing of 0 is stretched to 1 cycle so
                            // that consecutive pulses stay distinct.
                            cnt   <= (spacing_q == 16'd0) ? 16'd0 : spacing_q - 16'd1;
                            state <= S_SPACE;
                        end
                    end else begin
                        wcnt <= wcnt - 8'd1;
                    end
                end
                S_SPACE: begin
                    if (cnt == 16'd0) begin
                        wcnt  <= width_q - 8'd1;
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registers. No input reaches an output
    // combinationally.
    assign glitch_o  = (state == S_PULSE);
    assign busy_o    = (state != S_IDLE);
    assign armed_o   = (state == S_ARMED);
    assign done_o    = (state == S_DONE);
    assign state_dbg = state;
`ifdef GLITCH_TRIG_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
